tehb_fifo_break_r: RTL and testbench
====================================

// Module: tehb_fifo_break_r
// PURPOSE
//  Multi-slot ready-breaking elastic buffer: the ready-side counterpart of the
//  data/valid-breaking shift-register buffer. It gives a registered-only ins_ready,
//  so there is no combinational path outs_ready -> ins_ready.
//  When it is empty, data/valid pass through combinationally (0-cycle latency).
//  When the consumer stalls, up to NUM_SLOTS tokens are absorbed in FIFO order.
//  The buffering pass places it on handshake channels to cut long ready chains.
// PARAMETERS
//  NUM_SLOTS  4   storage depth in tokens; >=1; non-power-of-two allowed
//  DATA_TYPE  32  payload width in bits; >=1
// PORTS
//  clk         in   1            clock; all state on rising edge
//  rst         in   1            reset; asynchronous, active-low (0 = reset)
//  ins         in   DATA_TYPE    input payload
//  ins_valid   in   1            input valid
//  ins_ready   out  1            input ready; function of registered state and rst only
//  outs        out  DATA_TYPE    output payload
//  outs_valid  out  1            output valid
//  outs_ready  in   1            output ready
// BEHAVIOUR
//  - State: count (0..NUM_SLOTS), rd_ptr and wr_ptr (0..NUM_SLOTS-1), mem[NUM_SLOTS].
//    The data memory is not reset.
//  - Reset (rst=0, async): count=0, rd_ptr=0, wr_ptr=0.
//    While rst=0: ins_ready=0 and outs_valid=0.
//  - ins_ready  = rst & (count != NUM_SLOTS).
//  - Empty (count==0), bypass mode:
//    outs = ins, outs_valid = ins_valid.
//    If ins_valid & !outs_ready: write ins to mem[wr_ptr], wr_ptr++, count -> 1.
//    If ins_valid & outs_ready: the token passes through; no state change.
//  - Non-empty (count>0): outs = mem[rd_ptr], outs_valid = 1.
//    The input is never bypassed here, so FIFO order is kept.
//    read  = outs_ready      -> rd_ptr++
//    write = ins_valid & ins_ready -> mem[wr_ptr] = ins, wr_ptr++
//    count += write - read; a simultaneous read and write leaves count unchanged.
//  - Pointer wrap: the pointer after NUM_SLOTS-1 is 0 (explicit compare, not a modulo
//    on power-of-two).
//  - Full (count==NUM_SLOTS): ins_ready=0.
//    A read in that cycle sets count to NUM_SLOTS-1; ins_ready rises in the next cycle,
//    not the same one.
//  - Latency: 0 cycles when empty; otherwise a token leaves after all older tokens.
//  - Throughput: 1 token/cycle sustained whenever outs_ready=1.
//  - Reset mid-operation: stored tokens are discarded immediately; outs_valid drops
//    asynchronously.
//  - Handshake contract: outs_valid never deasserts, and outs never changes, while
//    outs_valid=1 & outs_ready=0 and count>0.
// CONFIGURATION
//  TEHB_FIFO_OCCUPANCY_EN
//    defined: adds output port occupancy [$clog2(NUM_SLOTS+1)-1:0] = count.
//      It reads 0 in reset and is registered only.
//    undefined: no port, identical handshake behaviour.
// STRUCTURE
//  - Shared header handshake_buffer_defs.vh holds:
//    a clog2-based pointer/count width macro, and a NUM_SLOTS>=1 elaboration check macro.
//  - Sub-module tehb_fifo_break_r_dataless holds count, the pointers, ins_ready,
//    outs_valid, and the bypass/empty flag.
//    It outputs wr_en, wr_ptr, rd_ptr and bypass.
//  - The top level holds mem and the outs mux (bypass ? ins : mem[rd_ptr]).
// TESTING
//  1 Bypass: count=0, outs_ready=1; ins=0xA5 with ins_valid for 1 cycle
//    -> same cycle outs=0xA5, outs_valid=1; count stays 0.
//  2 Fill: NUM_SLOTS=4, outs_ready=0; push 0x1,0x2,0x3,0x4
//    -> ins_ready=0 after the 4th accept.
//    Then outs_ready=1 -> outs 0x1,0x2,0x3,0x4 on consecutive cycles.
//  3 Full release: full, outs_ready pulses 1 cycle
//    -> ins_ready still 0 that cycle, 1 the next; count goes 4 -> 3.
//  4 Simultaneous: count=2, ins_valid=1 and outs_ready=1 for 10 cycles
//    -> count stays 2; ordering preserved.
//  5 Wrap: NUM_SLOTS=3; stream 9 tokens with random stalls
//    -> output equals the input sequence; pointers wrap 2 -> 0.
//  6 Async reset: count=3, drop rst between edges
//    -> outs_valid=0 and ins_ready=0 immediately.
//    After release: count=0, ins_ready=1, bypass works.

Source files
------------

// File: rtl/tehb_fifo_break_r_pkg.sv
// rtl/tehb_fifo_break_r_pkg.sv - shared types, defaults and helpers for the ready-breaking FIFO
//
// Contents:
//   DEFAULT_NUM_SLOTS / DEFAULT_DATA_TYPE  default depth and payload width
//   cnt_op_e                               occupancy update for one cycle
//   count_op(wr, rd)                       maps a write/read pair to a cnt_op_e
package tehb_fifo_break_r_pkg;

  localparam int DEFAULT_NUM_SLOTS = 4;
  localparam int DEFAULT_DATA_TYPE = 32;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A simultaneous write and read leaves the occupancy unchanged.
  function automatic cnt_op_e count_op(input logic wr, input logic rd);
    case ({wr, rd})
      2'b10:   return CNT_INC;
      2'b01:   return CNT_DEC;
      default: return CNT_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/handshake_buffer_defs.vh
// rtl/handshake_buffer_defs.vh - shared width and elaboration-check macros for handshake buffers
//
// Macros:
//   HB_PTR_W(n)       width of a slot pointer addressing n slots (at least 1 bit)
//   HB_CNT_W(n)       width of an occupancy counter holding 0..n
//   HB_CHECK_SLOTS(n) generate item that stops elaboration when n < 1
`ifndef HANDSHAKE_BUFFER_DEFS_VH
`define HANDSHAKE_BUFFER_DEFS_VH

`define HB_PTR_W(n) (((n) > 1) ? $clog2(n) : 1)
`define HB_CNT_W(n) ($clog2((n) + 1))

`define HB_CHECK_SLOTS(n) \
  if ((n) < 1) begin : g_num_slots_check \
    $error("NUM_SLOTS must be >= 1"); \
  end

`endif

// File: rtl/tehb_fifo_break_r_dataless.sv
// rtl/tehb_fifo_break_r_dataless.sv - control path of the ready-breaking FIFO (count, pointers, handshake)
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   ins_valid            producer valid
//   outs_ready           consumer ready
//   ins_ready            producer ready, decoded from registered count only
//   outs_valid           consumer valid (bypassed from ins_valid while empty)
//   wr_en, wr_ptr        storage write strobe and slot
//   rd_ptr               slot presented to the consumer when not bypassing
//   bypass               buffer is empty; payload comes straight from ins
//   count                current occupancy 0..NUM_SLOTS
`include "handshake_buffer_defs.vh"

module tehb_fifo_break_r_dataless
  import tehb_fifo_break_r_pkg::*;
#(
  parameter  int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  localparam int PTR_W     = `HB_PTR_W(NUM_SLOTS),
  localparam int CNT_W     = `HB_CNT_W(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  input  logic             outs_ready,
  output logic             ins_ready,
  output logic             outs_valid,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             bypass,
  output logic [CNT_W-1:0] count
);

  `HB_CHECK_SLOTS(NUM_SLOTS)

  logic rd_en;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    bypass     = (count == '0);
    ins_ready  = rst & (count != CNT_W'(NUM_SLOTS));
    outs_valid = rst & (bypass ? ins_valid : 1'b1);
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    if (bypass) begin
      // Only capture when the consumer refuses the bypassed token.
      wr_en = rst & ins_valid & ~outs_ready;
    end else begin
      // Never bypass while holding tokens, otherwise ordering breaks.
      wr_en = ins_valid & ins_ready;
      rd_en = outs_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      case (count_op(wr_en, rd_en))
        CNT_INC: count <= count + 1'b1;
        CNT_DEC: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tehb_fifo_break_r.sv
// rtl/tehb_fifo_break_r.sv - multi-slot ready-breaking elastic buffer with empty-state bypass
//
// Configuration macro: TEHB_FIFO_OCCUPANCY_EN adds the registered occupancy output.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   ins           input payload, ins_valid / ins_ready handshake
//   outs          output payload, outs_valid / outs_ready handshake
//   occupancy     (TEHB_FIFO_OCCUPANCY_EN only) stored token count
`include "handshake_buffer_defs.vh"

module tehb_fifo_break_r
  import tehb_fifo_break_r_pkg::*;
#(
  parameter  int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter  int DATA_TYPE = DEFAULT_DATA_TYPE,
  localparam int PTR_W     = `HB_PTR_W(NUM_SLOTS),
  localparam int CNT_W     = `HB_CNT_W(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
`ifdef TEHB_FIFO_OCCUPANCY_EN
  ,
  output logic [CNT_W-1:0]     occupancy
`endif
);

  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             bypass;
  logic [CNT_W-1:0] count;

  // Payload storage carries no reset; validity lives entirely in count.
  logic [DATA_TYPE-1:0] mem [NUM_SLOTS];

  tehb_fifo_break_r_dataless #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .outs_ready (outs_ready),
    .ins_ready  (ins_ready),
    .outs_valid (outs_valid),
    .wr_en      (wr_en),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .bypass     (bypass),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= ins;
  end

  assign outs = bypass ? ins : mem[rd_ptr];

`ifdef TEHB_FIFO_OCCUPANCY_EN
  assign occupancy = count;
`else
  logic unused_count;
  assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_tehb_fifo_break_r.sv
// tb/tb_tehb_fifo_break_r.sv - randomized self-checking bench for tehb_fifo_break_r
module tb_tehb_fifo_break_r;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        outs_ready;

  logic [31:0] outs4, outs3;
  logic        ov4, ov3, ir4, ir3;
`ifdef TEHB_FIFO_OCCUPANCY_EN
  logic [2:0]  occ4;
  logic [1:0]  occ3;
`endif

  tehb_fifo_break_r #(.NUM_SLOTS(4), .DATA_TYPE(32)) u_dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ir4),
    .outs(outs4), .outs_valid(ov4), .outs_ready(outs_ready)
`ifdef TEHB_FIFO_OCCUPANCY_EN
    , .occupancy(occ4)
`endif
  );

  tehb_fifo_break_r #(.NUM_SLOTS(3), .DATA_TYPE(32)) u_dut3 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ir3),
    .outs(outs3), .outs_valid(ov3), .outs_ready(outs_ready)
`ifdef TEHB_FIFO_OCCUPANCY_EN
    , .occupancy(occ3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          sel3;
  logic [31:0] o_data;
  logic        o_valid, o_ready;
  assign o_data  = sel3 ? outs3 : outs4;
  assign o_valid = sel3 ? ov3 : ov4;
  assign o_ready = sel3 ? ir3 : ir4;

  int checks = 0;
  int passes = 0;

  // Reference model: a queue of stored tokens with a depth limit.
  logic [31:0] q[$];

  function automatic int mdepth();
    return sel3 ? 3 : 4;
  endfunction

  function automatic logic exp_valid();
    if (!rst) return 1'b0;
    return (q.size() == 0) ? ins_valid : 1'b1;
  endfunction

  function automatic logic [31:0] exp_data();
    return (q.size() == 0) ? ins : q[0];
  endfunction

  function automatic logic exp_ready();
    return rst && (q.size() != mdepth());
  endfunction

  // Apply one clock edge to the model, then move to 1 time unit after the edge.
  task automatic advance();
    logic e_rdy;
    bit   was_empty;
    if (!rst) begin
      q.delete();
    end else begin
      e_rdy     = exp_ready();
      was_empty = (q.size() == 0);
      if (!was_empty && outs_ready) void'(q.pop_front());
      if (ins_valid && e_rdy && !(was_empty && outs_ready)) q.push_back(ins);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ins_valid = 1'b0; outs_ready = 1'b0; ins = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    sel3 = 0;
    rst = 1'b0; ins = 32'h55; ins_valid = 1'b1; outs_ready = 1'b1;
    #1;
    checks++; if (ir4 !== 1'b0) $display("FAIL reset_ins_ready: got %b want 0", ir4); else passes++;
    checks++; if (ov4 !== 1'b0) $display("FAIL reset_outs_valid: got %b want 0", ov4); else passes++;
    @(posedge clk); #1;
    rst = 1'b1; ins_valid = 1'b0; q.delete();
    #4;
    checks++; if (ir4 !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ir4); else passes++;
    checks++; if (ov4 !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", ov4); else passes++;
    advance();
  endtask

  task automatic test_bypass();
    sel3 = 0;
    do_reset();
    ins = 32'hA5; ins_valid = 1'b1; outs_ready = 1'b1;
    #4;
    checks++; if (o_valid !== 1'b1) $display("FAIL bypass_valid: got %b want 1", o_valid); else passes++;
    checks++; if (o_data !== 32'hA5) $display("FAIL bypass_data: got %h want a5", o_data); else passes++;
    advance();
    ins_valid = 1'b0;
    #4;
    checks++; if (o_valid !== 1'b0) $display("FAIL bypass_after_valid: got %b want 0", o_valid); else passes++;
    checks++; if (o_ready !== 1'b1) $display("FAIL bypass_after_ready: got %b want 1", o_ready); else passes++;
    advance();
  endtask

  task automatic test_fill();
    sel3 = 0;
    do_reset();
    outs_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ins = k; ins_valid = 1'b1;
      #4;
      checks++; if (o_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b want 1", k, o_ready); else passes++;
      checks++; if (o_data !== 32'h1) $display("FAIL fill_head_%0d: got %h want 1", k, o_data); else passes++;
      advance();
    end
    ins_valid = 1'b0;
    #4;
    checks++; if (o_ready !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", o_ready); else passes++;
    advance();
    outs_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #4;
      checks++; if (o_valid !== 1'b1) $display("FAIL drain_valid_%0d: got %b want 1", k, o_valid); else passes++;
      checks++; if (o_data !== 32'(k)) $display("FAIL drain_data_%0d: got %h want %h", k, o_data, k); else passes++;
      advance();
    end
    #4;
    checks++; if (o_valid !== 1'b0) $display("FAIL drain_empty_valid: got %b want 0", o_valid); else passes++;
    advance();
  endtask

  task automatic test_full_release();
    sel3 = 0;
    do_reset();
    outs_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ins = $urandom; ins_valid = 1'b1;
      advance();
    end
    ins_valid = 1'b0; outs_ready = 1'b1;
    #4;
    checks++; if (o_ready !== 1'b0) $display("FAIL release_same_cycle_ready: got %b want 0", o_ready); else passes++;
    checks++; if (o_data !== exp_data()) $display("FAIL release_data: got %h want %h", o_data, exp_data()); else passes++;
    advance();
    outs_ready = 1'b0;
    #4;
    checks++; if (o_ready !== 1'b1) $display("FAIL release_next_ready: got %b want 1", o_ready); else passes++;
    checks++; if (o_data !== exp_data()) $display("FAIL release_next_data: got %h want %h", o_data, exp_data()); else passes++;
    ins = $urandom; ins_valid = 1'b1;
    advance();
    ins_valid = 1'b0;
    #4;
    checks++; if (o_ready !== 1'b0) $display("FAIL refill_ready: got %b want 0", o_ready); else passes++;
    advance();
  endtask

  task automatic test_simultaneous();
    sel3 = 0;
    do_reset();
    outs_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ins = $urandom; ins_valid = 1'b1;
      advance();
    end
    outs_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ins = $urandom; ins_valid = 1'b1;
      #4;
      checks++; if (o_ready !== 1'b1) $display("FAIL simul_ready_%0d: got %b want 1", k, o_ready); else passes++;
      checks++; if (o_data !== exp_data()) $display("FAIL simul_data_%0d: got %h want %h", k, o_data, exp_data()); else passes++;
      advance();
    end
    ins_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      checks++; if (o_valid !== (k < 2)) $display("FAIL simul_drain_valid_%0d: got %b want %b", k, o_valid, k < 2); else passes++;
      if (k < 2) begin
        checks++; if (o_data !== exp_data()) $display("FAIL simul_drain_data_%0d: got %h want %h", k, o_data, exp_data()); else passes++;
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] tok[9];
    logic [31:0] got[$];
    int idx;
    int cyc;
    sel3 = 1;
    do_reset();
    for (int k = 0; k < 9; k++) tok[k] = $urandom;
    idx = 0; cyc = 0;
    while (got.size() < 9 && cyc < 300) begin
      ins_valid  = (idx < 9) && ($urandom_range(0, 3) != 0);
      ins        = (idx < 9) ? tok[idx] : 32'h0;
      outs_ready = (cyc >= 4) && ($urandom_range(0, 2) != 0);
      #4;
      checks++; if (o_valid !== exp_valid()) $display("FAIL wrap_valid_c%0d: got %b want %b", cyc, o_valid, exp_valid()); else passes++;
      checks++; if (o_ready !== exp_ready()) $display("FAIL wrap_ready_c%0d: got %b want %b", cyc, o_ready, exp_ready()); else passes++;
      if (exp_valid()) begin
        checks++; if (o_data !== exp_data()) $display("FAIL wrap_data_c%0d: got %h want %h", cyc, o_data, exp_data()); else passes++;
      end
      if (o_valid && outs_ready) got.push_back(o_data);
      if (ins_valid && exp_ready()) idx++;
      advance();
      cyc++;
    end
    checks++; if (got.size() != 9) $display("FAIL wrap_count: got %0d tokens want 9", got.size()); else passes++;
    for (int k = 0; k < 9 && k < got.size(); k++) begin
      checks++; if (got[k] !== tok[k]) $display("FAIL wrap_order_%0d: got %h want %h", k, got[k], tok[k]); else passes++;
    end
    ins_valid = 1'b0; outs_ready = 1'b0;
    sel3 = 0;
  endtask

  task automatic test_random();
    sel3 = 0;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      ins        = $urandom;
      ins_valid  = ($urandom_range(0, 2) != 0);
      outs_ready = ($urandom_range(0, 2) == 0) || (cyc >= 250);
      #4;
      checks++; if (o_valid !== exp_valid()) $display("FAIL rand_valid_c%0d: got %b want %b", cyc, o_valid, exp_valid()); else passes++;
      checks++; if (o_ready !== exp_ready()) $display("FAIL rand_ready_c%0d: got %b want %b", cyc, o_ready, exp_ready()); else passes++;
      if (exp_valid()) begin
        checks++; if (o_data !== exp_data()) $display("FAIL rand_data_c%0d: got %h want %h", cyc, o_data, exp_data()); else passes++;
      end
      advance();
    end
    ins_valid = 1'b0; outs_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    sel3 = 0;
    do_reset();
    outs_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ins = $urandom; ins_valid = 1'b1;
      advance();
    end
    ins_valid = 1'b0;
    #4;
    checks++; if (o_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", o_valid); else passes++;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", o_valid); else passes++;
    checks++; if (o_ready !== 1'b0) $display("FAIL arst_ready: got %b want 0", o_ready); else passes++;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    ins = 32'h3C; ins_valid = 1'b1; outs_ready = 1'b1;
    #4;
    checks++; if (o_ready !== 1'b1) $display("FAIL arst_post_ready: got %b want 1", o_ready); else passes++;
    checks++; if (o_valid !== 1'b1) $display("FAIL arst_post_valid: got %b want 1", o_valid); else passes++;
    checks++; if (o_data !== 32'h3C) $display("FAIL arst_post_data: got %h want 3c", o_data); else passes++;
    advance();
    ins_valid = 1'b0;
    #4;
    checks++; if (o_valid !== 1'b0) $display("FAIL arst_post_empty: got %b want 0", o_valid); else passes++;
    advance();
  endtask

  initial begin
    sel3 = 0;
    rst = 1'b0; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
    test_reset();
    test_bypass();
    test_fill();
    test_full_release();
    test_simultaneous();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
